// File: rtl/add_serial.sv
// Chunked serial adder: N-bit a + b + c_in, CHUNK bits per clock, LSB chunk first.
// Optional ADD_SERIAL_SUB_EN adds a 'sub' input that turns the operation into a - b.
module add_serial #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
`ifdef ADD_SERIAL_SUB_EN
  input  logic         sub,
`endif
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int NCH = N / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((N < 1) || (CHUNK < 1) || ((N % CHUNK) != 0)) begin : g_bad_cfg
      $error("add_serial: N must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          c_out_q, c_out_d;
  logic          ovf_q, ovf_d;
  logic          o_valid_q, o_valid_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_cy;
  logic             msb_cin;
  logic             b_inv;
  logic             cin_eff;

`ifdef ADD_SERIAL_SUB_EN
  assign b_inv   = sub;
  assign cin_eff = sub ? 1'b1 : c_in;
`else
  assign b_inv   = 1'b0;
  assign cin_eff = c_in;
`endif

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cnt_q == CW'(k)) begin
        chunk_a = a_q[k*CHUNK +: CHUNK];
        chunk_b = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign {chunk_cy, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
  // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the final chunk's top bit
  assign msb_cin = a_q[N-1] ^ b_q[N-1] ^ chunk_s[CHUNK-1];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    o_valid_d = o_valid_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = a;
          b_d     = b_inv ? ~b : b;
          carry_d = cin_eff;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < NCH; k++) begin
          if (cnt_q == CW'(k)) sum_d[k*CHUNK +: CHUNK] = chunk_s;
        end
        carry_d = chunk_cy;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          c_out_d   = chunk_cy;
          ovf_d     = msb_cin ^ chunk_cy;
          o_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (o_ready) begin
          o_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      c_out_q   <= 1'b0;
      ovf_q     <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      c_out_q   <= c_out_d;
      ovf_q     <= ovf_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign i_ready  = (state_q == IDLE) && !rst;
  assign o_valid  = o_valid_q;
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_add_serial.sv
// Directed bench for add_serial: a 32/8 instance for corner cases and a 4/1 instance swept exhaustively.
module tb_add_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv32, ir32, ov32, or32, cin32, co32, of32;
  logic [31:0] a32, b32, s32;
  logic        iv4, ir4, ov4, or4, cin4, co4, of4;
  logic [3:0]  a4, b4, s4;
`ifdef ADD_SERIAL_SUB_EN
  logic        sub32, sub4;
`endif

  int checks = 0;
  int errors = 0;

  add_serial #(.N(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst), .i_valid(iv32), .i_ready(ir32), .a(a32), .b(b32), .c_in(cin32),
`ifdef ADD_SERIAL_SUB_EN
    .sub(sub32),
`endif
    .o_valid(ov32), .o_ready(or32), .sum(s32), .c_out(co32), .overflow(of32)
  );

  add_serial #(.N(4), .CHUNK(1)) u_dut4 (
    .clk(clk), .rst(rst), .i_valid(iv4), .i_ready(ir4), .a(a4), .b(b4), .c_in(cin4),
`ifdef ADD_SERIAL_SUB_EN
    .sub(sub4),
`endif
    .o_valid(ov4), .o_ready(or4), .sum(s4), .c_out(co4), .overflow(of4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic sv, input logic [31:0] es,
                       input logic ec, input logic eo);
    int w;
    int lat;
    w = 0;
    while (!ir32 && w < 20) begin tick(); w++; end
    check({tag, "_rdy"}, 64'(ir32), 64'd1);
    a32 = av; b32 = bv; cin32 = cv;
`ifdef ADD_SERIAL_SUB_EN
    sub32 = sv;
`else
    if (sv) $display("note: sub requested without ADD_SERIAL_SUB_EN");
`endif
    iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    a32 = ~av; b32 = ~bv; cin32 = ~cv;
    lat = 0;
    while (!ov32 && lat < 20) begin tick(); lat++; end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, 64'(s32), 64'(es));
    check({tag, "_cout"}, 64'(co32), 64'(ec));
    check({tag, "_ovf"}, 64'(of32), 64'(eo));
    or32 = 1'b1;
    tick();
    or32 = 1'b0;
    check({tag, "_vld_drop"}, 64'(ov32), 64'd0);
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    logic [4:0] full;
    int sref;
    int lat;
    full = {1'b0, av} + {1'b0, bv} + {4'b0, cv};
    sref = (av[3] ? int'(av) - 16 : int'(av)) + (bv[3] ? int'(bv) - 16 : int'(bv)) + int'(cv);
    a4 = av; b4 = bv; cin4 = cv; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 20) begin tick(); lat++; end
    check("n4_lat", 64'(lat), 64'd4);
    check("n4_sum", 64'({co4, s4}), 64'(full));
    check("n4_ovf", 64'(of4), 64'((sref > 7) || (sref < -8)));
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef ADD_SERIAL_SUB_EN
    sub32 = 1'b0; sub4 = 1'b0;
`endif
    tick(); tick();
    check("rst_irdy", 64'(ir32), 64'd0);
    check("rst_ovld", 64'(ov32), 64'd0);
    check("rst_sum", 64'(s32), 64'd0);
    check("rst_cout", 64'(co32), 64'd0);
    check("rst_ovf", 64'(of32), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_irdy", 64'(ir32), 64'd1);

    run32("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run32("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    // backpressure, with competing operands presented during BUSY and DONE
    a32 = 32'h1234_5678; b32 = 32'h1111_1111; cin32 = 1'b1; iv32 = 1'b1;
    tick();
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 20) begin
      check("bp_busy_irdy", 64'(ir32), 64'd0);
      tick();
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_sum", 64'(s32), 64'h2345_678A);
      check("bp_hold_vld", 64'(ov32), 64'd1);
      check("bp_hold_irdy", 64'(ir32), 64'd0);
      tick();
    end
    check("bp_cout", 64'(co32), 64'd0);
    check("bp_ovf", 64'(of32), 64'd0);
    or32 = 1'b1; iv32 = 1'b0;
    tick();
    or32 = 1'b0;
    check("bp_vld_drop", 64'(ov32), 64'd0);
    check("bp_irdy_back", 64'(ir32), 64'd1);
    check("bp_sum_kept", 64'(s32), 64'h2345_678A);
    for (int i = 0; i < 6; i++) begin
      check("bp_not_queued", 64'(ov32), 64'd0);
      tick();
    end

    // reset in the second BUSY cycle discards the operation
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_vld", 64'(ov32), 64'd0);
    check("mrst_sum", 64'(s32), 64'd0);
    check("mrst_cout", 64'(co32), 64'd0);
    check("mrst_irdy", 64'(ir32), 64'd1);
    for (int i = 0; i < 6; i++) begin
      check("mrst_no_result", 64'(ov32), 64'd0);
      tick();
    end
    run32("after_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

`ifdef ADD_SERIAL_SUB_EN
    run32("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run32("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run32("sub_off", 32'd5, 32'd7, 1'b1, 1'b0, 32'd13, 1'b0, 1'b0);
`endif

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          run4(4'(ai), 4'(bi), 1'(ci));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
